eprisc_serial_bridge: RTL and testbench

//  Serial-to-bus debug bridge: the host-side initiator of the epRISC I/O bus, driven over a two-pin RS232 link.

---
 rtl/eprisc_serial_bridge.sv | 253 +++++++++++++++++++++++++
 tb/tb_eprisc_serial_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eprisc_serial_bridge.sv
`default_nettype none
// ============================================================================
// Module   : eprisc_serial_bridge
// Purpose  : RS232 (8N1) debug bridge that issues single read/write cycles on
//            the epRISC I/O bus. Optional macro SB_TIMEOUT_EN adds an
//            inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module eprisc_serial_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iRX,
    output logic              oTX,
    output logic [ADDR_W-1:0] oAddr,
    output logic [15:0]       oData,
    input  logic [15:0]       iData,
    output logic              oWrite,
    output logic              oEnable,
    output logic              oBusy,
    output logic              oFrameErr
);

    localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  CMD_WRITE   = 8'h57;
    localparam logic [7:0]  CMD_READ    = 8'h52;
    localparam logic [7:0]  REPLY_ACK   = 8'h06;
    localparam logic [7:0]  REPLY_NAK   = 8'h15;

    // ---------------------------------------------------------------- RX
    logic rx_meta, rx_sync;
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= iRX;
            rx_sync <= rx_meta;
        end
    end

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HI} rx_state_t;
    rx_state_t   rx_state, rx_next;
    logic [15:0] rx_timer;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_byte;
    logic        rx_tick, byte_valid, frame_err;

    assign rx_tick = (rx_timer == 16'd0);

    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            R_IDLE:    if (!rx_sync) rx_next = R_START;
            R_START:   if (rx_tick) rx_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:    if (rx_tick && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                        rx_next    = R_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        rx_next    = R_WAIT_HI;
                    end
                end
            end
            R_WAIT_HI: if (rx_sync) rx_next = R_IDLE;
            default:   rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rx_state <= R_IDLE;
            rx_timer <= 16'd0;
            rx_bit   <= 3'd0;
            rx_byte  <= 8'h00;
        end else begin
            rx_state <= rx_next;
            // Idle preloads the half-bit delay so the start bit is checked mid-bit.
            if (rx_state == R_IDLE)
                rx_timer <= HALF_RELOAD;
            else if (rx_tick)
                rx_timer <= BIT_RELOAD;
            else
                rx_timer <= rx_timer - 16'd1;
            if (rx_state == R_START)
                rx_bit <= 3'd0;
            if (rx_state == R_DATA && rx_tick) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                rx_bit  <= rx_bit + 3'd1;
            end
        end
    end

    assign oFrameErr = frame_err;

    // ---------------------------------------------------------------- TX
    logic        tx_load, tx_ready, tx_busy;
    logic [7:0]  tx_byte;
    logic [9:0]  tx_shift;
    logic [3:0]  tx_bit;
    logic [15:0] tx_timer;

    // Ready on the last cycle of a stop bit too, so replies go out back-to-back.
    assign tx_ready = !tx_busy || (tx_timer == 16'd0 && tx_bit == 4'd9);
    assign oTX      = tx_busy ? tx_shift[0] : 1'b1;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            tx_busy  <= 1'b0;
            tx_shift <= 10'h3FF;
            tx_bit   <= 4'd0;
            tx_timer <= 16'd0;
        end else if (tx_load && tx_ready) begin
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, tx_byte, 1'b0};
            tx_bit   <= 4'd0;
            tx_timer <= BIT_RELOAD;
        end else if (tx_busy) begin
            if (tx_timer == 16'd0) begin
                tx_timer <= BIT_RELOAD;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end
            end else begin
                tx_timer <= tx_timer - 16'd1;
            end
        end
    end

    // ------------------------------------------------------------ parser
    typedef enum logic [2:0] {P_CMD, P_ADDR, P_DHI, P_DLO, P_BUS, P_RESP} p_state_t;
    p_state_t          p_state, p_next;
    logic              is_write, lo_pending, timeout_hit;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dhi, lo_byte;

`ifdef SB_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic [31:0] to_count;
    logic        in_wait;

    assign in_wait     = (p_state == P_ADDR) || (p_state == P_DHI) || (p_state == P_DLO);
    assign timeout_hit = in_wait && (to_count == TIMEOUT_LAST);

    always_ff @(posedge iClk) begin
        if (iRst || byte_valid || !in_wait)
            to_count <= 32'd0;
        else
            to_count <= to_count + 32'd1;
    end
`else
    // TIMEOUT_BITS only matters when the timer is built.
    assign timeout_hit = 1'b0 && (TIMEOUT_BITS > 0);
`endif

    always_comb begin
        p_next  = p_state;
        tx_load = 1'b0;
        tx_byte = 8'h00;
        case (p_state)
            P_CMD: begin
                if (byte_valid) begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                        p_next = P_ADDR;
                    end else begin
                        tx_load = 1'b1;
                        tx_byte = REPLY_NAK;
                        p_next  = P_RESP;
                    end
                end
            end
            P_ADDR: begin
                if (frame_err)       p_next = P_CMD;
                else if (byte_valid) p_next = is_write ? P_DHI : P_BUS;
                else if (timeout_hit) p_next = P_CMD;
            end
            P_DHI: begin
                if (frame_err)       p_next = P_CMD;
                else if (byte_valid) p_next = P_DLO;
                else if (timeout_hit) p_next = P_CMD;
            end
            P_DLO: begin
                if (frame_err)       p_next = P_CMD;
                else if (byte_valid) p_next = P_BUS;
                else if (timeout_hit) p_next = P_CMD;
            end
            P_BUS: begin
                tx_load = 1'b1;
                tx_byte = is_write ? REPLY_ACK : iData[15:8];
                p_next  = P_RESP;
            end
            P_RESP: begin
                if (lo_pending) begin
                    tx_load = 1'b1;
                    tx_byte = lo_byte;
                end else if (!tx_busy) begin
                    p_next = P_CMD;
                end
            end
            default: p_next = P_CMD;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            p_state    <= P_CMD;
            is_write   <= 1'b0;
            addr_q     <= '0;
            dhi        <= 8'h00;
            lo_byte    <= 8'h00;
            lo_pending <= 1'b0;
            oAddr      <= '0;
            oData      <= 16'h0000;
        end else begin
            p_state <= p_next;
            if (p_state == P_CMD && byte_valid)
                is_write <= (rx_byte == CMD_WRITE);
            if (p_state == P_ADDR && byte_valid)
                addr_q <= rx_byte[ADDR_W-1:0];
            if (p_state == P_DHI && byte_valid)
                dhi <= rx_byte;
            if (p_next == P_BUS) begin
                oAddr <= (p_state == P_ADDR) ? rx_byte[ADDR_W-1:0] : addr_q;
                if (p_state == P_DLO)
                    oData <= {dhi, rx_byte};
            end
            if (p_state == P_BUS) begin
                lo_byte    <= iData[7:0];
                lo_pending <= !is_write;
            end else if (p_state == P_RESP && lo_pending && tx_ready) begin
                lo_pending <= 1'b0;
            end
        end
    end

    assign oEnable = (p_state == P_BUS);
    assign oWrite  = (p_state == P_BUS) && is_write;
    assign oBusy   = (p_state != P_CMD);

endmodule
`default_nettype wire

// File: tb/tb_eprisc_serial_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_eprisc_serial_bridge
// Purpose  : Directed self-checking bench for eprisc_serial_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eprisc_serial_bridge;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] rdata = 16'hBEEF;
    logic        tx, wr, en, busy, ferr;
    logic [7:0]  addr;
    logic [15:0] wdata;

    always #5 clk = ~clk;

    eprisc_serial_bridge #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (8),
        .TIMEOUT_BITS(40)
    ) dut (
        .iClk     (clk),
        .iRst     (rst),
        .iRX      (rx),
        .oTX      (tx),
        .oAddr    (addr),
        .oData    (wdata),
        .iData    (rdata),
        .oWrite   (wr),
        .oEnable  (en),
        .oBusy    (busy),
        .oFrameErr(ferr)
    );

    int tests = 0, fails = 0, cyc = 0;
    int en_count = 0, en_cycle = 0, fe_count = 0, bad_wr = 0, bad_stop = 0;
    logic [7:0]  en_addr = 8'h00;
    logic [15:0] en_data = 16'h0000;
    logic        en_wr = 1'b0;
    int          tx_q[$];
    int          tx_start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en === 1'b1) begin
            en_count <= en_count + 1;
            en_cycle <= cyc;
            en_addr  <= addr;
            en_data  <= wdata;
            en_wr    <= wr;
        end
        if (en !== 1'b1 && wr === 1'b1) bad_wr <= bad_wr + 1;
        if (ferr === 1'b1) fe_count <= fe_count + 1;
    end

    // Serial decoder for oTX, sampling each bit in its middle.
    initial begin
        logic [7:0] b;
        int         st;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                st = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) bad_stop = bad_stop + 1;
                tx_q.push_back(int'(b));
                tx_start_q.push_back(st);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(n < 4000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    function automatic int q_at(input int idx);
        return (tx_q.size() > idx) ? tx_q[idx] : -1;
    endfunction

    function automatic int st_at(input int idx);
        return (tx_start_q.size() > idx) ? tx_start_q[idx] : -1000;
    endfunction

    task automatic clear_q();
        tx_q.delete();
        tx_start_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_bus", {7'd0, addr, wdata, wr}, 32'd0);
        check("reset_flags", {29'd0, en, busy, ferr}, 32'd0);

        // Write 0x1234 to address 0x05
        clear_q();
        send_byte(8'h57, 1'b1);
        check("busy_after_cmd", 32'(busy), 32'd1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_idle("write");
        check("write_en_count", 32'(en_count), 32'd1);
        check("write_we", 32'(en_wr), 32'd1);
        check("write_addr", 32'(en_addr), 32'h05);
        check("write_data", 32'(en_data), 32'h1234);
        check("write_reply_len", 32'(tx_q.size()), 32'd1);
        check("write_reply", 32'(q_at(0)), 32'h06);
        check("write_latency", 32'(st_at(0) - en_cycle), 32'd1);
        check("write_busy_low", 32'(busy), 32'd0);
        check("write_hold", {8'd0, addr, wdata}, 32'h0005_1234);

        // Read from address 0x03
        clear_q();
        send_byte(8'h52, 1'b1);
        send_byte(8'h03, 1'b1);
        wait_idle("read");
        check("read_en_count", 32'(en_count), 32'd2);
        check("read_we", 32'(en_wr), 32'd0);
        check("read_addr", 32'(en_addr), 32'h03);
        check("read_reply_len", 32'(tx_q.size()), 32'd2);
        check("read_reply_hi", 32'(q_at(0)), 32'hBE);
        check("read_reply_lo", 32'(q_at(1)), 32'hEF);
        check("read_back_to_back", 32'(st_at(1) - st_at(0)), 32'(10 * CPB));
        check("read_latency", 32'(st_at(0) - en_cycle), 32'd1);

        // Unknown command
        clear_q();
        send_byte(8'h41, 1'b1);
        wait_idle("badcmd");
        check("badcmd_no_bus", 32'(en_count), 32'd2);
        check("badcmd_reply_len", 32'(tx_q.size()), 32'd1);
        check("badcmd_reply", 32'(q_at(0)), 32'h15);

        // Short glitch on RX
        clear_q();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (25 * CPB) @(negedge clk);
        check("glitch_no_reply", 32'(tx_q.size()), 32'd0);
        check("glitch_no_bus", 32'(en_count), 32'd2);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_no_ferr", 32'(fe_count), 32'd0);

        // Framing error then a normal read
        clear_q();
        send_byte(8'h57, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        check("frame_err_pulse", 32'(fe_count), 32'd1);
        check("frame_no_reply", 32'(tx_q.size()), 32'd0);
        check("frame_busy", 32'(busy), 32'd0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_idle("frame_read");
        check("frame_read_en", 32'(en_count), 32'd3);
        check("frame_read_addr", 32'(en_addr), 32'h00);
        check("frame_read_reply", {q_at(0)[15:0], q_at(1)[15:0]}, 32'h00BE_00EF);

        // Reset in the middle of the DHI byte
        clear_q();
        send_byte(8'h57, 1'b1);
        send_byte(8'h01, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("rst_mid_no_bus", 32'(en_count), 32'd3);
        check("rst_mid_no_reply", 32'(tx_q.size()), 32'd0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h01, 1'b1);
        wait_idle("rst_read");
        check("rst_read_en", 32'(en_count), 32'd4);
        check("rst_read_addr_we", {23'd0, en_addr, en_wr}, 32'h002);
        check("rst_read_reply", {q_at(0)[15:0], q_at(1)[15:0]}, 32'h00BE_00EF);

`ifdef SB_TIMEOUT_EN
        // Abandoned write times out, then a read works
        clear_q();
        send_byte(8'h57, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (40 * CPB + 20) @(negedge clk);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_no_reply", 32'(tx_q.size()), 32'd0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h01, 1'b1);
        wait_idle("timeout_read");
        check("timeout_read_en", 32'(en_count), 32'd5);
        check("timeout_read_we", 32'(en_wr), 32'd0);
        check("timeout_read_reply", {q_at(0)[15:0], q_at(1)[15:0]}, 32'h00BE_00EF);
`endif

        check("write_only_with_enable", 32'(bad_wr), 32'd0);
        check("tx_stop_bits_high", 32'(bad_stop), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
